// File: rtl/lcd_read_fsm.sv
// lcd_read_fsm: one HD44780 4-bit read cycle (upper then lower nibble), returns the assembled byte.
// Latency start->done is 1+2*(T_SETUP+T_EHIGH+T_GAP) cycles; start is ignored outside IDLE. Optional LCD_BUSY_POLL_EN re-reads while BF=1.
module lcd_read_fsm #(
    parameter int T_SETUP   = 2,
    parameter int T_EHIGH   = 12,
    parameter int T_GAP     = 50,
    parameter int MAX_POLLS = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rs,
    input  logic       SF_D8,
    input  logic       SF_D9,
    input  logic       SF_D10,
    input  logic       SF_D11,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       lcd_bus_read,
    output logic       ready,
    output logic [7:0] data_out,
    output logic       busy_flag,
    output logic       done,
    output logic       timeout
);

    typedef enum logic [2:0] {
        IDLE, SETUP_U, EHIGH_U, GAP_U, SETUP_L, EHIGH_L, GAP_L, DONE
    } state_t;

    state_t      state, state_n;
    logic [10:0] cnt;
    logic        rs_lat;
    logic [3:0]  upper_q, lower_q;
    logic [3:0]  bus_nib;

    assign bus_nib = {SF_D11, SF_D10, SF_D9, SF_D8};

`ifdef LCD_BUSY_POLL_EN
    logic [7:0] poll_cnt;
    logic       timeout_q;
    logic       bf_seen;
    assign bf_seen = !rs_lat && upper_q[3];
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = SETUP_U;
            SETUP_U: if (cnt == 11'(T_SETUP - 1)) state_n = EHIGH_U;
            EHIGH_U: if (cnt == 11'(T_EHIGH - 1)) state_n = GAP_U;
            GAP_U:   if (cnt == 11'(T_GAP - 1))   state_n = SETUP_L;
            SETUP_L: if (cnt == 11'(T_SETUP - 1)) state_n = EHIGH_L;
            EHIGH_L: if (cnt == 11'(T_EHIGH - 1)) state_n = GAP_L;
            GAP_L: begin
                if (cnt == 11'(T_GAP - 1)) begin
                    state_n = DONE;
`ifdef LCD_BUSY_POLL_EN
                    // Controller still busy: read again unless the poll budget is spent.
                    if (bf_seen && poll_cnt != 8'(MAX_POLLS - 1))
                        state_n = SETUP_U;
`endif
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rs_lat    <= 1'b0;
            upper_q   <= '0;
            lower_q   <= '0;
            data_out  <= '0;
            busy_flag <= 1'b0;
            LCD_E     <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
            poll_cnt  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= (state_n != state || state == IDLE) ? 11'd0 : cnt + 11'd1;
            // E comes straight from a flop so the strobe cannot glitch on state decode.
            LCD_E <= (state_n == EHIGH_U) || (state_n == EHIGH_L);
            if (state == IDLE && start) begin
                rs_lat    <= rs;
`ifdef LCD_BUSY_POLL_EN
                poll_cnt  <= '0;
                timeout_q <= 1'b0;
`endif
            end
            if (state == EHIGH_U && state_n != EHIGH_U) upper_q <= bus_nib;
            if (state == EHIGH_L && state_n != EHIGH_L) lower_q <= bus_nib;
            if (state == GAP_L && state_n == DONE) begin
                data_out  <= {upper_q, lower_q};
                busy_flag <= !rs_lat && upper_q[3];
`ifdef LCD_BUSY_POLL_EN
                timeout_q <= bf_seen;
`endif
            end
`ifdef LCD_BUSY_POLL_EN
            if (state == GAP_L && state_n == SETUP_U) poll_cnt <= poll_cnt + 8'd1;
`endif
        end
    end

    assign ready        = (state == IDLE);
    assign done         = (state == DONE);
    assign lcd_bus_read = (state != IDLE);
    assign LCD_RW       = 1'b1;
    assign LCD_RS       = (state == IDLE) ? 1'b0 : rs_lat;

endmodule
